// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32M multiply/divide types and constants
//   XLEN        : operand/result width
//   mdu_op_e    : funct3 encodings of the eight RV32M operations
//   mdu_state_e : iterative unit control states
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// rtl/mdu_sign_fix.sv - conditional two's-complement negate (magnitude / sign fix-up)
//   a      in  W  value
//   negate in  1  when high, y = -a, otherwise y = a
//   y      out W  result
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         negate,
  output logic [W-1:0] y
);

  assign y = negate ? (~a + W'(1)) : a;

endmodule

// File: rtl/mdu_iterative.sv
// rtl/mdu_iterative.sv - iterative RV32M multiply/divide unit, one radix-2 step per cycle
//   clk      in  1     clock, rising edge
//   reset    in  1     synchronous active-high reset
//   start    in  1     request, accepted only while busy=0
//   op       in  3     funct3 operation code
//   rs1_data in  XLEN  operand A
//   rs2_data in  XLEN  operand B
//   rd_in    in  5     destination register, captured at acceptance
//   busy     out 1     from the cycle after acceptance through the done cycle
//   done     out 1     one-cycle completion pulse
//   result   out XLEN  result, held until the next completion
//   rd_out   out 5     captured destination register
//   we_out   out 1     done and rd_out != 0
module mdu_iterative
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            we_out
);

  localparam int CW = $clog2(XLEN);

  mdu_state_e        state;
  mdu_op_e           op_q;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;       // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   opd;       // multiplicand or divisor magnitude
  logic [XLEN-1:0]   spec_res;
  logic              spec_q, div_q, neg_q, neg_r;

  // Operand preparation
  mdu_op_e         op_in;
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, spec_val;
  logic            div_zero, div_ovf;

  assign op_in    = mdu_op_e'(op);
  assign a_signed = (op_in == MDU_MULH) || (op_in == MDU_MULHSU) ||
                    (op_in == MDU_DIV)  || (op_in == MDU_REM);
  assign b_signed = (op_in == MDU_MULH) || (op_in == MDU_DIV) || (op_in == MDU_REM);
  assign a_neg    = a_signed && rs1_data[XLEN-1];
  assign b_neg    = b_signed && rs2_data[XLEN-1];

  mdu_sign_fix #(.W(XLEN)) u_fix_a (.a(rs1_data), .negate(a_neg), .y(a_mag));
  mdu_sign_fix #(.W(XLEN)) u_fix_b (.a(rs2_data), .negate(b_neg), .y(b_mag));

  assign div_zero = op[2] && (rs2_data == '0);
  assign div_ovf  = op[2] && !op[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (rs2_data == '1);

  // op[1] separates REM/REMU from DIV/DIVU; overflow's DIV answer equals rs1
  always_comb begin
    spec_val = '0;
    if (div_zero) spec_val = op[1] ? rs1_data : '1;
    else          spec_val = op[1] ? '0 : rs1_data;
  end

  // Iteration datapath
  logic [XLEN:0] mul_sum, div_diff;

  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
  assign div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opd};

  // Final sign fix-up; the low half of the negated 2*XLEN value is the negated quotient
  logic [2*XLEN-1:0] p_fix;
  logic [XLEN-1:0]   r_fix, fin_val;

  mdu_sign_fix #(.W(2*XLEN)) u_fix_p (.a(acc), .negate(neg_q), .y(p_fix));
  mdu_sign_fix #(.W(XLEN))   u_fix_r (.a(acc[2*XLEN-1:XLEN]), .negate(neg_r), .y(r_fix));

  always_comb begin
    fin_val = '0;
    if (spec_q) begin
      fin_val = spec_res;
    end else begin
      case (op_q)
        MDU_MUL, MDU_DIV, MDU_DIVU:      fin_val = p_fix[XLEN-1:0];
        MDU_MULH, MDU_MULHSU, MDU_MULHU: fin_val = p_fix[2*XLEN-1:XLEN];
        MDU_REM, MDU_REMU:               fin_val = r_fix;
        default:                         fin_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= MDU_MUL;
      cnt      <= '0;
      acc      <= '0;
      opd      <= '0;
      spec_res <= '0;
      spec_q   <= 1'b0;
      div_q    <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      we_out   <= 1'b0;
      result   <= '0;
      rd_out   <= '0;
    end else begin
      done   <= 1'b0;
      we_out <= 1'b0;
      case (state)
        IDLE: begin
          // busy is still high in the done cycle, which blocks a start there
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            busy     <= 1'b1;
            op_q     <= op_in;
            rd_out   <= rd_in;
            cnt      <= '0;
            div_q    <= op[2];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            spec_q   <= div_zero || div_ovf;
            spec_res <= spec_val;
            acc      <= {{XLEN{1'b0}}, (op[2] ? a_mag : b_mag)};
            opd      <= op[2] ? b_mag : a_mag;
            state    <= (div_zero || div_ovf) ? FIN : CALC;
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          if (div_q) begin
            // restoring step: keep the difference only when it did not borrow
            if (!div_diff[XLEN]) acc <= {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else                 acc <= {acc[2*XLEN-2:0], 1'b0};
          end else begin
            acc <= {mul_sum, acc[XLEN-1:1]};
          end
          if (cnt == CW'(XLEN - 1)) state <= FIN;
        end
        FIN: begin
          result <= fin_val;
          done   <= 1'b1;
          we_out <= (rd_out != 5'd0);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// tb/tb_mdu_iterative.sv - self-checking bench for mdu_iterative
module tb_mdu_iterative;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done, we_out;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int total = 0;
  int bad = 0;

  mdu_iterative #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out), .we_out(we_out)
  );

  always #5 clk = ~clk;

  // Reference model: plain 64-bit arithmetic on the RV32M definitions
  function automatic logic [31:0] ref_mdu(input logic [2:0] o, input logic [31:0] a, b);
    longint sa, sb, p;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd0: begin up = ua * ub; return up[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        up = ua / ub; return up[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        up = ua % ub; return up[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a, b);
    if (o >= 3'd4 && (b == 0 || (o[0] == 1'b0 && a == 32'h80000000 && b == 32'hFFFFFFFF)))
      return 2;
    return 34;
  endfunction

  // Issue one operation with start in cycle 0 and observe it until done.
  // Inputs are scrambled while busy; with inject, a competing start is raised in cycle 10.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, b, input logic [4:0] rd,
                        input bit inject, output logic [31:0] res, output int lat,
                        output bit busy_ok, output logic we_at_done, output bit we_stray,
                        output logic [4:0] rdo);
    @(negedge clk);
    busy_ok = (busy === 1'b0);
    start = 1'b1; op = o; rs1_data = a; rs2_data = b; rd_in = rd;
    lat = -1; we_stray = 1'b0; we_at_done = 1'b0;
    for (int c = 1; c <= 60 && lat < 0; c++) begin
      @(negedge clk);
      start = (inject && c == 10);
      op = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'($urandom);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (we_out === 1'b1 && done !== 1'b1) we_stray = 1'b1;
      if (done === 1'b1) begin
        lat = c;
        we_at_done = we_out;
      end
    end
    start = 1'b0;
    res = result;
    rdo = rd_out;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total += 5;
    if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0)    begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
    if (we_out !== 1'b0)  begin bad++; $display("FAIL reset_we: got %b expected 0", we_out); end
    if (result !== 32'd0) begin bad++; $display("FAIL reset_result: got %h expected 0", result); end
    if (rd_out !== 5'd0)  begin bad++; $display("FAIL reset_rd: got %0d expected 0", rd_out); end
    reset = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a, b, exp;
    logic [4:0]  rd;
    int          lat;
  } vec_t;

  task automatic test_directed;
    vec_t v[12];
    logic [31:0] res; int lat; bit bok, wst; logic wd; logic [4:0] rdo;
    v[0]  = '{3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 5'd5, 34};
    v[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 5'd6, 34};
    v[2]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 5'd7, 34};
    v[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 34};
    v[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 5'd9, 34};
    v[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 5'd10, 34};
    v[6]  = '{3'd5, 32'd100, 32'd7, 32'd14, 5'd11, 34};
    v[7]  = '{3'd7, 32'd100, 32'd7, 32'd2, 5'd12, 34};
    v[8]  = '{3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 5'd13, 2};
    v[9]  = '{3'd6, 32'd5, 32'd0, 32'd5, 5'd14, 2};
    v[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 5'd15, 2};
    v[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 5'd16, 2};
    foreach (v[i]) begin
      run_op(v[i].o, v[i].a, v[i].b, v[i].rd, 1'b0, res, lat, bok, wd, wst, rdo);
      total += 5;
      if (res !== v[i].exp) begin bad++; $display("FAIL dir%0d_result: got %h expected %h", i, res, v[i].exp); end
      if (lat != v[i].lat)  begin bad++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, v[i].lat); end
      if (!bok)             begin bad++; $display("FAIL dir%0d_busy: busy window wrong, expected high cycles 1..%0d", i, v[i].lat); end
      if (rdo !== v[i].rd)  begin bad++; $display("FAIL dir%0d_rd: got %0d expected %0d", i, rdo, v[i].rd); end
      if (wd !== 1'b1 || wst) begin bad++; $display("FAIL dir%0d_we: got %b stray=%b expected 1 only with done", i, wd, wst); end
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b, res; logic [2:0] o; logic [4:0] rd;
    int lat; bit bok, wst; logic wd; logic [4:0] rdo;
    logic [31:0] pool[4] = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000};
    for (int i = 0; i < 60; i++) begin
      o  = 3'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 3)] :
           (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      run_op(o, a, b, rd, 1'b0, res, lat, bok, wd, wst, rdo);
      total += 4;
      if (res !== ref_mdu(o, a, b)) begin bad++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, res, ref_mdu(o, a, b)); end
      if (lat != ref_latency(o, a, b) || !bok) begin bad++; $display("FAIL rnd%0d_timing: got lat %0d busy_ok %0b expected lat %0d", i, lat, bok, ref_latency(o, a, b)); end
      if (rdo !== rd) begin bad++; $display("FAIL rnd%0d_rd: got %0d expected %0d", i, rdo, rd); end
      if (wd !== (rd != 5'd0) || wst) begin bad++; $display("FAIL rnd%0d_we: got %b stray=%b expected %b", i, wd, wst, rd != 5'd0); end
    end
  endtask

  task automatic test_ignore_start;
    logic [31:0] res; int lat; bit bok, wst, extra; logic wd; logic [4:0] rdo;
    run_op(3'd0, 32'd1234, 32'd5678, 5'd3, 1'b1, res, lat, bok, wd, wst, rdo);
    extra = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) extra = 1'b1;
    end
    total += 3;
    if (res !== 32'd7006652) begin bad++; $display("FAIL ignore_result: got %h expected %h", res, 32'd7006652); end
    if (lat != 34 || !bok)  begin bad++; $display("FAIL ignore_timing: got lat %0d busy_ok %0b expected 34", lat, bok); end
    if (extra)              begin bad++; $display("FAIL ignore_queue: got activity after done expected idle"); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] res; int lat; bit bok, wst; logic wd; logic [4:0] rdo;
    run_op(3'd5, 32'd1000, 32'd3, 5'd1, 1'b0, res, lat, bok, wd, wst, rdo);
    total += 1;
    if (res !== 32'd333) begin bad++; $display("FAIL b2b_first: got %h expected %h", res, 32'd333); end
    run_op(3'd7, 32'd1000, 32'd3, 5'd2, 1'b0, res, lat, bok, wd, wst, rdo);
    total += 2;
    if (res !== 32'd1) begin bad++; $display("FAIL b2b_second: got %h expected 1", res); end
    if (lat != 34 || !bok) begin bad++; $display("FAIL b2b_timing: got lat %0d busy_ok %0b expected 34", lat, bok); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] res; int lat; bit bok, wst, stray_done; logic wd; logic [4:0] rdo;
    @(negedge clk);
    start = 1'b1; op = 3'd4; rs1_data = 32'd999; rs2_data = 32'd7; rd_in = 5'd4;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 15) reset = 1'b1;
    end
    @(negedge clk);
    total += 3;
    if (busy !== 1'b0)    begin bad++; $display("FAIL abort_busy: got %b expected 0", busy); end
    if (done !== 1'b0)    begin bad++; $display("FAIL abort_done: got %b expected 0", done); end
    if (result !== 32'd0) begin bad++; $display("FAIL abort_result: got %h expected 0", result); end
    reset = 1'b0;
    stray_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) stray_done = 1'b1;
    end
    total += 1;
    if (stray_done) begin bad++; $display("FAIL abort_no_done: got activity expected none"); end
    run_op(3'd0, 32'd3, 32'd4, 5'd9, 1'b0, res, lat, bok, wd, wst, rdo);
    total += 2;
    if (res !== 32'd12) begin bad++; $display("FAIL post_reset_mul: got %h expected 0000000c", res); end
    if (lat != 34 || !bok) begin bad++; $display("FAIL post_reset_timing: got lat %0d busy_ok %0b expected 34", lat, bok); end
    run_op(3'd0, 32'd5, 32'd6, 5'd0, 1'b0, res, lat, bok, wd, wst, rdo);
    total += 3;
    if (lat != 34) begin bad++; $display("FAIL rd0_done: got lat %0d expected 34", lat); end
    if (wd !== 1'b0 || wst) begin bad++; $display("FAIL rd0_we: got %b stray=%b expected 0", wd, wst); end
    if (res !== 32'd30) begin bad++; $display("FAIL rd0_result: got %h expected 0000001e", res); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_ignore_start;
    test_back_to_back;
    test_random;
    test_reset_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
